gs232c_fetch_redirect_ctl: RTL and testbench

Fetch-stage branch redirect controller that sits directly after the instruction predecoder.
- Accepts one fetched instruction per cycle, together with the predecoder flags for that instruction (bl_b, brop, jrop, jrra, link, offs, sign).
- Computes static next-PC predictions and maintains a return address stack (RAS).
- Sequences a one-cycle redirect to the PC generator and squashes the wrong-path fetch beat.
- Passes instructions downstream through a one-entry registered stage with valid/ready handshake.

---
 rtl/gs232c_bp_pkg.sv | 20 ++
 rtl/gs232c_ras.sv | 73 +++++++
 rtl/gs232c_fetch_redirect_ctl.sv | 151 +++++++++++++++
 tb/tb_gs232c_fetch_redirect_ctl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs232c_bp_pkg.sv
// Shared definitions for the gs232c fetch redirect controller.
//   - FSM state encoding (RUN / SQUASH) as legacy-compatible localparams
//   - Default RAS depth
//   - sext_offs26_to_pc: sign-extends a 26-bit word offset to a byte offset
package gs232c_bp_pkg;

  typedef logic [0:0] fsm_state_t;

  localparam fsm_state_t ST_RUN    = 1'b0;
  localparam fsm_state_t ST_SQUASH = 1'b1;

  localparam int unsigned RAS_DEPTH_DEFAULT = 8;

  // Returns a 64-bit byte offset; callers truncate to their PC width
  // (modulo arithmetic makes the truncation exact).
  function automatic logic [63:0] sext_offs26_to_pc(input logic [25:0] offs);
    return {{36{offs[25]}}, offs, 2'b00};
  endfunction

endpackage

// File: rtl/gs232c_ras.sv
// Return address stack: circular buffer with pointer and saturating count.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   push, push_data  push a return address
//   pop              pop the top entry (ignored while empty)
//   push && pop      replace the top entry in place (plain push while empty)
//   top, empty       combinational top-of-stack and empty flag
module gs232c_ras
  import gs232c_bp_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  // ptr_q addresses the next free slot; the top lives at ptr_q - 1.
  logic [PtrW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [PtrW:0]   count_q, count_d;
  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic            wr_en;

  assign empty   = (count_q == '0);
  assign top_idx = ptr_q - PtrW'(1);
  assign top     = mem_q[top_idx];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else begin
      if (pop && !empty) begin
        ptr_d   = top_idx;
        count_d = count_q - (PtrW+1)'(1);
      end
      if (push) begin
        // Full pushes wrap onto the oldest entry; count saturates.
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        ptr_d  = ptr_q + PtrW'(1);
        if (count_q != (PtrW+1)'(RAS_DEPTH)) count_d = count_q + (PtrW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/gs232c_fetch_redirect_ctl.sv
// Fetch-stage branch redirect controller placed after the predecoder.
// Predicts static next-PC targets, keeps a RAS, issues a one-cycle redirect
// and squashes the wrong-path beat that follows a taken prediction.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_pc/in_inst  fetch beat handshake and payload
//   in_bl_b .. in_sign, in_offs      predecoder flags and word offset
//   out_valid/out_ready/out_*        registered downstream stage + prediction
//   redirect_valid/redirect_pc       one-cycle redirect to the PC generator
//   ex_flush                         backend flush, highest priority
// Build option: GS232C_BTFN_PRED_EN enables backward-taken prediction of in_brop.
module gs232c_fetch_redirect_ctl
  import gs232c_bp_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_bl_b,
  input  logic            in_brop,
  input  logic            in_jrop,
  input  logic            in_jrra,
  input  logic            in_link,
  input  logic            in_sign,
  input  logic [25:0]     in_offs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_pred_taken,
  output logic [PC_W-1:0] out_pred_target,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            ex_flush
);

  fsm_state_t      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [PC_W-1:0] out_pc_q, out_pred_target_q, redirect_pc_q, redirect_pc_d;
  logic [31:0]     out_inst_q;
  logic            out_pred_taken_q;

  logic            acc, run_acc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target, tgt, pc_plus4, ras_top;
  logic            ras_empty;

  // jr (non-ra) is never predicted; its flag is intentionally ignored.
  logic unused_flags;
`ifdef GS232C_BTFN_PRED_EN
  assign unused_flags = in_jrop;
`else
  assign unused_flags = ^{in_jrop, in_brop, in_sign};
`endif

  // The SQUASH cycle is exactly the cycle the redirect pulse is visible.
  assign redirect_valid = (state_q == ST_SQUASH);
  assign in_ready       = redirect_valid || !out_valid_q || out_ready;
  assign acc            = in_valid && in_ready;
  assign run_acc        = acc && (state_q == ST_RUN) && !ex_flush;

  assign tgt      = in_pc + PC_W'(sext_offs26_to_pc(in_offs));
  assign pc_plus4 = in_pc + PC_W'(4);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (in_bl_b) begin
      pred_taken  = 1'b1;
      pred_target = tgt;
    end else if (in_jrra && !ras_empty) begin
      pred_taken  = 1'b1;
      pred_target = ras_top;
`ifdef GS232C_BTFN_PRED_EN
    end else if (in_brop && in_sign) begin
      pred_taken  = 1'b1;
      pred_target = tgt;
`endif
    end
  end

  gs232c_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .resetn    (resetn),
    .push      (run_acc && in_link),
    .pop       (run_acc && in_jrra),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    redirect_pc_d = redirect_pc_q;
    if (ex_flush) begin
      state_d     = ST_RUN;
      out_valid_d = 1'b0;
    end else if (state_q == ST_SQUASH) begin
      // Wrong-path beat is consumed and dropped; output only drains.
      state_d = ST_RUN;
      if (out_ready) out_valid_d = 1'b0;
    end else if (acc) begin
      out_valid_d = 1'b1;
      if (pred_taken) begin
        state_d       = ST_SQUASH;
        redirect_pc_d = pred_target;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q           <= ST_RUN;
      out_valid_q       <= 1'b0;
      out_pc_q          <= '0;
      out_inst_q        <= '0;
      out_pred_taken_q  <= 1'b0;
      out_pred_target_q <= '0;
      redirect_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      redirect_pc_q <= redirect_pc_d;
      if (run_acc) begin
        out_pc_q          <= in_pc;
        out_inst_q        <= in_inst;
        out_pred_taken_q  <= pred_taken;
        out_pred_target_q <= pred_target;
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_inst        = out_inst_q;
  assign out_pred_taken  = out_pred_taken_q;
  assign out_pred_target = out_pred_target_q;
  assign redirect_pc     = redirect_pc_q;

endmodule

// File: tb/tb_gs232c_fetch_redirect_ctl.sv
module tb_gs232c_fetch_redirect_ctl;

`ifdef GS232C_BTFN_PRED_EN
  localparam bit BtfnEn = 1'b1;
`else
  localparam bit BtfnEn = 1'b0;
`endif

  logic        clk, resetn;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_bl_b, in_brop, in_jrop, in_jrra, in_link, in_sign;
  logic [25:0] in_offs;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_pred_target, redirect_pc;
  logic        out_pred_taken, redirect_valid, ex_flush;

  int checks = 0;
  int failures = 0;

  // Behavioural reference model state.
  bit          m_out_valid, m_taken, m_redir;
  logic [31:0] m_out_pc, m_out_inst, m_target, m_redir_pc;
  logic [31:0] ras[$];

  gs232c_fetch_redirect_ctl dut (
    .clk             (clk),
    .resetn          (resetn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_inst         (in_inst),
    .in_bl_b         (in_bl_b),
    .in_brop         (in_brop),
    .in_jrop         (in_jrop),
    .in_jrra         (in_jrra),
    .in_link         (in_link),
    .in_sign         (in_sign),
    .in_offs         (in_offs),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ex_flush        (ex_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_out_valid = 0; m_taken = 0; m_redir = 0;
    m_out_pc = 0; m_out_inst = 0; m_target = 0; m_redir_pc = 0;
    ras.delete();
  endtask

  task automatic model_step();
    bit rdy, taken;
    logic [31:0] target;
    int o;
    rdy = m_redir || !m_out_valid || out_ready;
    if (ex_flush) begin
      m_out_valid = 0;
      m_redir = 0;
    end else if (m_redir) begin
      m_redir = 0;
      if (out_ready) m_out_valid = 0;
    end else if (in_valid && rdy) begin
      o = in_offs[25] ? int'(in_offs) - (1 << 26) : int'(in_offs);
      taken = 0;
      target = 0;
      if (in_bl_b) begin
        taken = 1; target = in_pc + 32'(o * 4);
      end else if (in_jrra && ras.size() > 0) begin
        taken = 1; target = ras[ras.size()-1];
      end else if (BtfnEn && in_brop && in_sign) begin
        taken = 1; target = in_pc + 32'(o * 4);
      end
      if (in_jrra && in_link && ras.size() > 0) begin
        ras[ras.size()-1] = in_pc + 4;
      end else begin
        if (in_jrra && ras.size() > 0) void'(ras.pop_back());
        if (in_link) begin
          ras.push_back(in_pc + 4);
          if (ras.size() > 8) void'(ras.pop_front());
        end
      end
      m_out_valid = 1; m_out_pc = in_pc; m_out_inst = in_inst;
      m_taken = taken; m_target = target;
      if (taken) begin
        m_redir = 1; m_redir_pc = target;
      end
    end else if (out_ready) begin
      m_out_valid = 0;
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; in_pc = 0; in_inst = 0; in_offs = 0;
    in_bl_b = 0; in_brop = 0; in_jrop = 0; in_jrra = 0; in_link = 0; in_sign = 0;
    ex_flush = 0;
  endtask

  task automatic set_beat(input logic [31:0] pc, input logic [31:0] inst);
    set_idle();
    in_valid = 1; in_pc = pc; in_inst = inst;
  endtask

  task automatic test_reset();
    resetn = 0; out_ready = 1; set_idle();
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin failures++;
      $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect_valid, redirect_pc); end
    checks++; if (out_pc !== 0 || out_inst !== 0 || out_pred_taken !== 0 || out_pred_target !== 0) begin
      failures++; $display("FAIL reset_out_regs got=%h/%h/%b/%h exp=all 0", out_pc, out_inst,
                           out_pred_taken, out_pred_target); end
    model_reset();
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    out_ready = 1;
    set_beat(32'h1C000000, 32'h50001000); in_bl_b = 1; in_offs = 26'd4;
    tick();
    checks++; if (out_valid !== 1 || out_pred_taken !== 1 || out_pred_target !== 32'h1C000010) begin
      failures++; $display("FAIL b_pred got=%b/%b/%h exp=1/1/1c000010", out_valid, out_pred_taken,
                           out_pred_target); end
    checks++; if (redirect_valid !== 1 || redirect_pc !== 32'h1C000010) begin failures++;
      $display("FAIL b_redirect got=%b/%h exp=1/1c000010", redirect_valid, redirect_pc); end
    set_beat(32'h1C000004, 32'h02800000);
    #1;
    checks++; if (in_ready !== 1) begin failures++; $display("FAIL squash_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (redirect_valid !== 0 || out_valid !== 0) begin failures++;
      $display("FAIL squash_discard got=%b/%b exp=0/0", redirect_valid, out_valid); end
    set_idle();
    tick();
  endtask

  task automatic test_call_return();
    out_ready = 1;
    set_beat(32'h1C000100, 32'h54001000); in_bl_b = 1; in_link = 1; in_offs = 26'd4;
    tick();
    checks++; if (redirect_valid !== 1 || redirect_pc !== 32'h1C000110) begin failures++;
      $display("FAIL bl_redirect got=%b/%h exp=1/1c000110", redirect_valid, redirect_pc); end
    set_idle(); tick();
    set_beat(32'h1C000110, 32'h4C000020); in_jrra = 1;
    tick();
    checks++; if (out_pred_taken !== 1 || redirect_valid !== 1 || redirect_pc !== 32'h1C000104) begin
      failures++; $display("FAIL jrra_return got=%b/%b/%h exp=1/1/1c000104", out_pred_taken,
                           redirect_valid, redirect_pc); end
    set_idle(); tick();
    set_beat(32'h1C000104, 32'h4C000020); in_jrra = 1;
    tick();
    checks++; if (out_pred_taken !== 0 || redirect_valid !== 0 || out_pred_target !== 0) begin
      failures++; $display("FAIL jrra_empty got=%b/%b/%h exp=0/0/0", out_pred_taken, redirect_valid,
                           out_pred_target); end
    set_idle(); tick();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_t;
    out_ready = 1;
    for (int k = 0; k < 9; k++) begin
      set_beat(32'h1C000000 + 32'(k * 16), 32'h54001000); in_bl_b = 1; in_link = 1; in_offs = 26'd4;
      tick();
      set_idle(); tick();
    end
    for (int i = 0; i < 9; i++) begin
      set_beat(32'h1C001000, 32'h4C000020); in_jrra = 1;
      tick();
      if (i < 8) begin
        exp_t = 32'h1C000084 - 32'(i * 16);
        checks++; if (out_pred_taken !== 1 || out_pred_target !== exp_t || redirect_pc !== exp_t) begin
          failures++; $display("FAIL ras_pop%0d got=%b/%h/%h exp=1/%h", i, out_pred_taken,
                               out_pred_target, redirect_pc, exp_t); end
      end else begin
        checks++; if (out_pred_taken !== 0 || redirect_valid !== 0) begin failures++;
          $display("FAIL ras_pop_empty got=%b/%b exp=0/0", out_pred_taken, redirect_valid); end
      end
      set_idle(); tick();
    end
  endtask

  task automatic test_btfn();
    out_ready = 1;
    set_beat(32'h1C000200, 32'h5BFFF000); in_brop = 1; in_sign = 1; in_offs = 26'h3FFFFFC;
    tick();
    if (BtfnEn) begin
      checks++; if (out_pred_taken !== 1 || redirect_valid !== 1 || redirect_pc !== 32'h1C0001F0) begin
        failures++; $display("FAIL btfn_taken got=%b/%b/%h exp=1/1/1c0001f0", out_pred_taken,
                             redirect_valid, redirect_pc); end
    end else begin
      checks++; if (out_pred_taken !== 0 || redirect_valid !== 0) begin failures++;
        $display("FAIL btfn_off got=%b/%b exp=0/0", out_pred_taken, redirect_valid); end
    end
    set_idle(); tick(); tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    set_beat(32'h1C000400, 32'h02800001);
    tick();
    checks++; if (out_valid !== 1 || out_pc !== 32'h1C000400) begin failures++;
      $display("FAIL bp_load got=%b/%h exp=1/1c000400", out_valid, out_pc); end
    set_beat(32'h1C000404, 32'h02800002);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 0) begin failures++; $display("FAIL bp_stall%0d in_ready got=%b exp=0", i, in_ready); end
      tick();
      checks++; if (out_pc !== 32'h1C000400 || out_inst !== 32'h02800001 || out_valid !== 1) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/1c000400/02800001", i, out_valid,
                             out_pc, out_inst); end
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1) begin failures++; $display("FAIL bp_release in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1 || out_pc !== 32'h1C000404 || out_inst !== 32'h02800002) begin
      failures++; $display("FAIL bp_accept got=%b/%h/%h exp=1/1c000404/02800002", out_valid, out_pc,
                           out_inst); end
    set_idle(); tick();
  endtask

  task automatic test_flush();
    out_ready = 1;
    set_beat(32'h1C000300, 32'h54001000); in_bl_b = 1; in_link = 1; in_offs = 26'd4;
    tick();
    set_idle(); tick();
    set_beat(32'h1C000500, 32'h54001000); in_bl_b = 1; in_link = 1; in_offs = 26'd4; ex_flush = 1;
    tick();
    checks++; if (redirect_valid !== 0 || out_valid !== 0) begin failures++;
      $display("FAIL flush_cancel got=%b/%b exp=0/0", redirect_valid, out_valid); end
    set_idle(); tick();
    checks++; if (redirect_valid !== 0) begin failures++; $display("FAIL flush_no_late_redirect got=%b exp=0", redirect_valid); end
    set_beat(32'h1C000600, 32'h4C000020); in_jrra = 1;
    tick();
    checks++; if (out_pred_taken !== 1 || redirect_pc !== 32'h1C000304) begin failures++;
      $display("FAIL flush_ras_kept got=%b/%h exp=1/1c000304", out_pred_taken, redirect_pc); end
    set_idle(); tick();
  endtask

  task automatic test_squash_reset();
    out_ready = 1;
    set_beat(32'h1C000700, 32'h50002000); in_bl_b = 1; in_offs = 26'd8;
    tick();
    checks++; if (redirect_valid !== 1 || redirect_pc !== 32'h1C000720) begin failures++;
      $display("FAIL sr_redirect got=%b/%h exp=1/1c000720", redirect_valid, redirect_pc); end
    set_idle();
    #2 resetn = 0;
    #1;
    checks++; if (redirect_valid !== 0 || out_valid !== 0 || in_ready !== 1 || redirect_pc !== 0) begin
      failures++; $display("FAIL sr_async got=%b/%b/%b/%h exp=0/0/1/0", redirect_valid, out_valid,
                           in_ready, redirect_pc); end
    model_reset();
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 800; n++) begin
      set_idle();
      in_valid  = ($urandom_range(0, 9) < 7);
      in_pc     = {4'h1, 26'($urandom), 2'b00};
      in_inst   = $urandom;
      in_offs   = 26'($urandom);
      in_bl_b   = ($urandom_range(0, 99) < 15);
      in_jrra   = ($urandom_range(0, 99) < 20);
      in_link   = ($urandom_range(0, 99) < 20);
      in_brop   = ($urandom_range(0, 99) < 20);
      in_jrop   = ($urandom_range(0, 99) < 10);
      in_sign   = $urandom_range(0, 1);
      ex_flush  = ($urandom_range(0, 99) < 5);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      checks++; if (in_ready !== (m_redir || !m_out_valid || out_ready)) begin failures++;
        $display("FAIL rnd%0d in_ready got=%b exp=%b", n, in_ready, (m_redir || !m_out_valid || out_ready)); end
      tick();
      checks++;
      if (out_valid !== m_out_valid || out_pc !== m_out_pc || out_inst !== m_out_inst ||
          out_pred_taken !== m_taken || out_pred_target !== m_target ||
          redirect_valid !== m_redir || redirect_pc !== m_redir_pc) begin
        failures++;
        if (errs < 10) $display("FAIL rnd%0d outputs got=%b/%h/%h/%b/%h/%b/%h exp=%b/%h/%h/%b/%h/%b/%h",
          n, out_valid, out_pc, out_inst, out_pred_taken, out_pred_target, redirect_valid,
          redirect_pc, m_out_valid, m_out_pc, m_out_inst, m_taken, m_target, m_redir, m_redir_pc);
        errs++;
      end
    end
    set_idle(); tick();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_return();
    test_ras_overflow();
    test_btfn();
    test_backpressure();
    test_flush();
    test_squash_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
